register_bank: RTL and testbench



---
 rtl/register_bank.sv | 37 +++
 tb/tb_register_bank.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// Four-entry general-purpose register bank: synchronous writes selected by LOAD_SELECT,
// asynchronous active-low clear, and a combinational read mux with no write bypass.
package register_bank_pkg;
  localparam logic [1:0] LOAD_REG_A = 2'd0;
  localparam logic [1:0] LOAD_REG_B = 2'd1;
  localparam logic [1:0] LOAD_REG_C = 2'd2;
  localparam logic [1:0] LOAD_REG_D = 2'd3;
endpackage

module register_bank #(
  parameter int DATA_WIDTH = 19,
  parameter int NUM_REGS   = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  LOAD_REG,
  input  logic [1:0]            LOAD_SELECT,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (LOAD_REG) begin
      regs[LOAD_SELECT] <= data_in;
    end
  end

  // Read path shows stored contents only; a pending write appears after the edge.
  assign data_out = regs[LOAD_SELECT];

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: reset sequences, a directed vector table and randomized
// writes/reads checked against an array model of the four registers.
module tb_register_bank;
  import register_bank_pkg::*;

  localparam int W = 19;

  logic         CLK;
  logic         RST_N;
  logic         LOAD_REG;
  logic [1:0]   LOAD_SELECT;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;

  int checks;
  int failures;

  logic [W-1:0] mdl [4];

  typedef struct {
    logic         load;
    logic [1:0]   sel;
    logic [W-1:0] din;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl [16];

  register_bank #(.DATA_WIDTH(W), .NUM_REGS(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .LOAD_REG   (LOAD_REG),
    .LOAD_SELECT(LOAD_SELECT),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Walks all four selects; takes 4 time units.
  task automatic read_all_zero(input string name);
    for (int s = 0; s < 4; s++) begin
      LOAD_SELECT = 2'(s);
      #1;
      check(name, data_out, '0);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) mdl[i] = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_model();

    tbl[0]  = '{1'b1, LOAD_REG_A, 19'h000AA, 19'h000AA};
    tbl[1]  = '{1'b1, LOAD_REG_B, 19'h000BB, 19'h000BB};
    tbl[2]  = '{1'b1, LOAD_REG_C, 19'h000CC, 19'h000CC};
    tbl[3]  = '{1'b0, LOAD_REG_A, 19'h12345, 19'h000AA};
    tbl[4]  = '{1'b0, LOAD_REG_B, 19'h12345, 19'h000BB};
    tbl[5]  = '{1'b0, LOAD_REG_C, 19'h12345, 19'h000CC};
    tbl[6]  = '{1'b0, LOAD_REG_D, 19'h12345, 19'h00000};
    tbl[7]  = '{1'b0, LOAD_REG_A, 19'h12345, 19'h000AA};
    tbl[8]  = '{1'b1, LOAD_REG_D, 19'h7FFFF, 19'h7FFFF};
    tbl[9]  = '{1'b0, LOAD_REG_A, 19'h00000, 19'h000AA};
    tbl[10] = '{1'b0, LOAD_REG_B, 19'h00000, 19'h000BB};
    tbl[11] = '{1'b0, LOAD_REG_C, 19'h00000, 19'h000CC};
    tbl[12] = '{1'b0, LOAD_REG_D, 19'h00000, 19'h7FFFF};
    tbl[13] = '{1'b1, LOAD_REG_A, 19'h00011, 19'h00011};
    tbl[14] = '{1'b1, LOAD_REG_A, 19'h00022, 19'h00022};
    tbl[15] = '{1'b0, LOAD_REG_B, 19'h3FFFF, 19'h000BB};

    // Power-on reset
    RST_N       = 1'b0;
    LOAD_REG    = 1'b0;
    LOAD_SELECT = LOAD_REG_A;
    data_in     = '0;
    #2;
    read_all_zero("rst_init");
    step();
    step();
    RST_N = 1'b1;
    step();
    read_all_zero("post_rst");

    // Load A, then clear asynchronously between edges
    LOAD_REG    = 1'b1;
    LOAD_SELECT = LOAD_REG_A;
    data_in     = 19'h0002A;
    step();
    LOAD_REG = 1'b0;
    check("load_a_2a", data_out, 19'h0002A);
    #2;
    RST_N = 1'b0;
    read_all_zero("async_rst");
    step();
    step();
    RST_N = 1'b1;
    read_all_zero("rst_release");
    clear_model();

    // Directed table
    for (int i = 0; i < 16; i++) begin
      LOAD_REG    = tbl[i].load;
      LOAD_SELECT = tbl[i].sel;
      data_in     = tbl[i].din;
      step();
      if (tbl[i].load) mdl[tbl[i].sel] = tbl[i].din;
      check($sformatf("table[%0d]", i), data_out, tbl[i].exp);
    end

    // Write cycle: old value visible until the edge, no bypass of data_in
    LOAD_REG    = 1'b1;
    LOAD_SELECT = LOAD_REG_A;
    data_in     = 19'h00033;
    #1;
    check("no_bypass_pre", data_out, 19'h00022);
    step();
    check("no_bypass_post", data_out, 19'h00033);
    mdl[0] = 19'h00033;

    // Reset pulled mid-burst; an edge while held low must write nothing
    LOAD_SELECT = LOAD_REG_B;
    data_in     = 19'h00001;
    step();
    check("burst_b", data_out, 19'h00001);
    LOAD_SELECT = LOAD_REG_C;
    data_in     = 19'h00002;
    #2;
    RST_N = 1'b0;
    read_all_zero("burst_rst");
    step();
    read_all_zero("rst_edge_nowrite");
    #1;
    RST_N       = 1'b1;
    LOAD_SELECT = LOAD_REG_C;
    data_in     = 19'h00055;
    step();
    check("first_write_after_rst", data_out, 19'h00055);
    LOAD_REG    = 1'b0;
    LOAD_SELECT = LOAD_REG_A;
    #1;
    check("others_clear_after_rst", data_out, 19'h00000);
    clear_model();
    mdl[2] = 19'h00055;

    // Randomized traffic against the array model
    for (int n = 0; n < 400; n++) begin
      LOAD_REG    = 1'($urandom_range(0, 1));
      LOAD_SELECT = 2'($urandom_range(0, 3));
      data_in     = W'($urandom);
      #1;
      check("rnd_pre_edge", data_out, mdl[LOAD_SELECT]);
      if ($urandom_range(0, 39) == 0) begin
        RST_N = 1'b0;
        #1;
        clear_model();
        check("rnd_async_rst", data_out, '0);
        step();
        RST_N = 1'b1;
      end else begin
        step();
        if (LOAD_REG) mdl[LOAD_SELECT] = data_in;
      end
      check("rnd_post_edge", data_out, mdl[LOAD_SELECT]);
      LOAD_SELECT = 2'($urandom_range(0, 3));
      #1;
      check("rnd_read", data_out, mdl[LOAD_SELECT]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
